ddr2_dist_fifo: RTL

- Parametrised single-clock FIFO built on distributed (LUT) RAM: synchronous write, asynchronous read.
- Generalises the fixed 16-deep, MEMORY_WIDTH-wide dual-port RAM slice to any width and power-of-two depth.
- Adds pointer management, full/empty/almost flags, occupancy count, error pulses, and a selectable first-word-fall-through (FWFT) or registered-read mode.
- Sits between the DDR2 read-capture/write-data paths and the user interface as the standard data buffer.

---
 rtl/ddr2_dist_fifo_pkg.sv | 21 ++
 rtl/ddr2_dist_ram.sv | 26 ++
 rtl/ddr2_dist_fifo.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ddr2_dist_fifo_pkg.sv
// Shared constants for the DDR2 distributed-RAM data buffers: default memory
// width, FIFO geometry and flag thresholds, plus a constant log2 helper.
package ddr2_dist_fifo_pkg;

  localparam int MEMORY_WIDTH      = 64;
  localparam int FIFO_ADDR_WIDTH   = 4;
  localparam int FIFO_DEPTH        = 1 << FIFO_ADDR_WIDTH;
  localparam int FIFO_AFULL_LEVEL  = 12;
  localparam int FIFO_AEMPTY_LEVEL = 2;

  // Ceiling log2 for sizing address buses from a depth.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ddr2_dist_ram.sv
// Distributed (LUT) RAM: synchronous write port, asynchronous read port.
// Contents are deliberately not reset so the array maps onto LUT RAM.
module ddr2_dist_ram
  import ddr2_dist_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = MEMORY_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dpo
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  // Write port: store d at waddr on the rising edge when enabled.
  always_ff @(posedge clk0) begin
    if (we) mem[waddr] <= d;
  end

  assign dpo = mem[raddr];

endmodule

// File: rtl/ddr2_dist_fifo.sv
// Single-clock FIFO over distributed RAM. Pointers carry an extra wrap bit so
// full and empty are distinguishable; flags and count are registered from the
// post-access pointer values. FWFT selects combinational head-of-queue output
// or a registered read with one cycle of latency.
module ddr2_dist_fifo
  import ddr2_dist_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = MEMORY_WIDTH,
  parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
  parameter int AFULL_LEVEL  = FIFO_AFULL_LEVEL,
  parameter int AEMPTY_LEVEL = FIFO_AEMPTY_LEVEL,
  parameter int FWFT         = 1
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  wr_ovf,
  output logic                  rd_unf
);

  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);

  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   wr_ptr_nxt, rd_ptr_nxt, count_nxt, ptr_diff;
  logic                  wr_acc, rd_acc;
  logic                  full_nxt, empty_nxt;
  logic                  full_q, empty_q, afull_q, aempty_q, ovf_q, unf_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [DATA_WIDTH-1:0] ram_q;

  // ---- stage p0: accept decisions from start-of-cycle flags ----

  // Accept logic and next pointer/flag values after this cycle's accesses.
  always_comb begin
    wr_acc     = wr_en && !full_q;
    rd_acc     = rd_en && !empty_q;
    wr_ptr_nxt = wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_acc};
    rd_ptr_nxt = rd_ptr + {{ADDR_WIDTH{1'b0}}, rd_acc};
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    full_nxt   = (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]) &&
                 (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]);
  end

  ddr2_dist_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk0  (clk0),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .d     (din),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .dpo   (ram_q)
  );

  // ---- stage p1: registered pointers, flags, count and error pulses ----

  // Pointer and status registers; reset empties the FIFO immediately.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count_q  <= count_nxt;
      full_q   <= full_nxt;
      empty_q  <= empty_nxt;
      afull_q  <= (count_nxt >= AFULL_CNT);
      aempty_q <= (count_nxt <= AEMPTY_CNT);
      ovf_q    <= wr_en && full_q;
      unf_q    <= rd_en && empty_q;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout       = ram_q;
      assign dout_valid = !empty_q;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_p1;
      logic                  vld_p1;

      // Registered read: capture the head word on an accepted pop, else hold.
      always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
          dout_p1 <= '0;
          vld_p1  <= 1'b0;
        end else begin
          vld_p1 <= rd_acc;
          if (rd_acc) dout_p1 <= ram_q;
        end
      end

      assign dout       = dout_p1;
      assign dout_valid = vld_p1;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign wr_ovf       = ovf_q;
  assign rd_unf       = unf_q;

  assign ptr_diff = wr_ptr - rd_ptr;

  a_count_matches_ptrs: assert property (@(posedge clk0) disable iff (!rst0_n)
    count_q == ptr_diff);
  a_not_full_and_empty: assert property (@(posedge clk0) disable iff (!rst0_n)
    !(full_q && empty_q));

endmodule
